// File: rtl/seq_booth_mult_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier.
// FSM state encoding and Booth recoding pair constants.
package seq_booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;

    localparam int CNT_W = 6;

endpackage

// File: rtl/seq_booth_mult_booth_step.sv
// One radix-2 Booth step: add/subtract/none on the high half,
// then arithmetic shift right of the {hi, lo, q-1} accumulator.
module booth_step
    import seq_booth_mult_pkg::*;
#(
    parameter int M = 16
) (
    input  logic [2*M:0] acc,
    input  logic [M-1:0] a,
    output logic [2*M:0] acc_nxt
);

    logic [M-1:0] hi;
    logic [M-1:0] lo;
    logic [1:0]   pair;
    logic [M:0]   hi_x;
    logic [M:0]   a_x;
    logic [M:0]   sum;

    assign hi   = acc[2*M:M+1];
    assign lo   = acc[M:1];
    assign pair = acc[1:0];
    assign hi_x = {hi[M-1], hi};
    assign a_x  = {a[M-1], a};

    // One guard bit keeps the most-negative multiplicand exact;
    // the shift drops it back into M bits without loss.
    always_comb begin
        sum = hi_x;
        unique case (1'b1)
            (pair == BOOTH_ADD): sum = hi_x + a_x;
            (pair == BOOTH_SUB): sum = hi_x - a_x;
            default:             sum = hi_x;
        endcase
    end

    assign acc_nxt = {sum, lo};

endmodule

// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes.
// Define SEQ_BOOTH_MULT_UNSIGNED_EN to add the tc (signed select) port.
module seq_booth_mult
    import seq_booth_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef SEQ_BOOTH_MULT_UNSIGNED_EN
    input  logic               tc,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out
);

`ifdef SEQ_BOOTH_MULT_UNSIGNED_EN
    localparam int M = WIDTH + 1;
`else
    localparam int M = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(M - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [M-1:0]       a_q, a_d;
    logic [2*M:0]       acc_q, acc_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic [2*M:0]       acc_nxt;
    logic [M-1:0]       a_ext;
    logic [M-1:0]       b_ext;

`ifdef SEQ_BOOTH_MULT_UNSIGNED_EN
    assign a_ext = {tc & A[WIDTH-1], A};
    assign b_ext = {tc & B[WIDTH-1], B};
`else
    assign a_ext = A;
    assign b_ext = B;
`endif

    booth_step #(.M(M)) u_step (
        .acc     (acc_q),
        .a       (a_q),
        .acc_nxt (acc_nxt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        acc_d   = acc_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_ext;
                    acc_d   = {{M{1'b0}}, b_ext, 1'b0};
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Product lives in acc[2M:1]; keep its low 2*WIDTH bits.
                    out_d   = acc_nxt[2*WIDTH:1];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;

endmodule

// File: tb/tb_seq_booth_mult.sv
// Directed-vector bench for seq_booth_mult (WIDTH=16).
// Covers latency, corner operands, backpressure, mid-CALC reset.
module tb_seq_booth_mult;

    localparam int W = 16;
`ifdef SEQ_BOOTH_MULT_UNSIGNED_EN
    localparam int N = W + 1;
`else
    localparam int N = W;
`endif

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out;
`ifdef SEQ_BOOTH_MULT_UNSIGNED_EN
    logic           tc;
`endif

    int n_pass;
    int n_total;

    seq_booth_mult #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SEQ_BOOTH_MULT_UNSIGNED_EN
        .tc        (tc),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2*W-1:0] exp);
        int cyc;
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, 64'(cyc), 64'(N));
        check({tag, "_out"}, 64'(out), 64'(exp));
        if (out_ready) begin
            tick();
            check({tag, "_idle"}, 64'({in_ready, out_valid}), 64'b10);
        end
    endtask

    initial begin
        logic [2*W-1:0] held;
        int             cyc;
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
`ifdef SEQ_BOOTH_MULT_UNSIGNED_EN
        tc        = 1'b1;
`endif
        #1;
        check("rst_state", 64'({in_ready, out_valid}), 64'b10);
        check("rst_out", 64'(out), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        run("p14x16", 16'd14, 16'd16, 32'h0000_00E0);
        run("m3x5", 16'hFFFD, 16'd5, 32'hFFFF_FFF1);
        run("minxmin", 16'h8000, 16'h8000, 32'h4000_0000);
        run("zero", 16'd0, 16'd16, 32'h0000_0000);
        run("minxmax", 16'h8000, 16'h7FFF, 32'hC000_8000);
        run("maxxmin", 16'h7FFF, 16'h8000, 32'hC000_8000);
        run("m1xm1", 16'hFFFF, 16'hFFFF, 32'h0000_0001);

        // Backpressure: result must sit still, new operands ignored.
        out_ready = 1'b0;
        run("hold", 16'd7, 16'hFFFE, 32'hFFFF_FFF2);
        held = out;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            A        = 16'h1234;
            B        = 16'h5678;
            tick();
            check("hold_vld", 64'(out_valid), 64'd1);
            check("hold_rdy", 64'(in_ready), 64'd0);
            check("hold_out", 64'(out), 64'(held));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("acc_idle", 64'({in_ready, out_valid}), 64'b10);
        check("acc_keep", 64'(out), 64'hFFFF_FFF2);
        tick();
        check("acc_nostart", 64'(in_ready), 64'd1);

        // Reset asserted in the 7th CALC cycle.
        A        = 16'd100;
        B        = 16'd100;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("mid_calc", 64'({in_ready, out_valid}), 64'b00);
        rst_n = 1'b0;
        #1;
        check("mrst_state", 64'({in_ready, out_valid}), 64'b10);
        check("mrst_out", 64'(out), 64'd0);
        #2;
        rst_n = 1'b1;
        run("p15x13", 16'd15, 16'd13, 32'h0000_00C3);

`ifdef SEQ_BOOTH_MULT_UNSIGNED_EN
        tc = 1'b0;
        run("u_ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        run("u_8000", 16'h8000, 16'h8000, 32'h4000_0000);
        tc = 1'b1;
        run("s_ffff", 16'hFFFF, 16'hFFFF, 32'h0000_0001);
`endif

        cyc = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_booth_mult.md
SEQ_BOOTH_MULT -- requirements
Module: seq_booth_mult

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits, legal range 4..32.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port in_valid, input, 1: operands A/B valid.
REQ-005 Port in_ready, output, 1: block can accept operands.
REQ-006 Port A, input, WIDTH: multiplicand, two's complement.
REQ-007 Port B, input, WIDTH: multiplier, two's complement.
REQ-008 Port out_valid, output, 1: product valid.
REQ-009 Port out_ready, input, 1: consumer accepts product.
REQ-010 Port out, output, 2*WIDTH: signed product A*B.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-012 in_ready SHALL equal (state==IDLE), combinationally from the state register only.
REQ-013 Input handshake: in_valid&&in_ready at an edge SHALL capture A and B, clear the iteration counter, and move IDLE->CALC.
REQ-014 CALC SHALL perform one radix-2 Booth step per cycle on a 2*WIDTH+1 accumulator: pair {q0,q-1}: 01 add A, 10 subtract A, 00/11 none, then arithmetic shift right by one.
REQ-015 CALC SHALL last exactly N cycles (N=WIDTH, or WIDTH+1 per REQ-024), then move CALC->DONE.
REQ-016 out_valid SHALL be high exactly when state==DONE; first high N cycles after the input-handshake edge.
REQ-017 out SHALL hold the exact product, sign-extended to 2*WIDTH bits, and stay stable while out_valid is high.
REQ-018 Output handshake: out_valid&&out_ready at an edge SHALL move DONE->IDLE; out_ready low SHALL hold DONE indefinitely.
REQ-019 A, B and in_valid SHALL be ignored outside IDLE; a new operation cannot start in the same cycle a result is accepted (in_ready is low in DONE).
REQ-020 The most-negative operand (-2^(WIDTH-1)) SHALL be handled exactly on either or both inputs; no overflow is possible.
REQ-021 out SHALL retain the last product after leaving DONE, until the next DONE overwrites it.

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, out_valid=0, in_ready=1, out=0, counter=0, accumulator=0, at any point including mid-CALC or in DONE; the in-flight operation is discarded.
REQ-023 After rst_n deasserts, the first edge SHALL already accept a handshake.

Configuration
REQ-024 Macro SEQ_BOOTH_MULT_UNSIGNED_EN defined: extra input port tc (1 bit, sampled at input handshake); tc=1 treats A/B as signed, tc=0 as unsigned; operands extended by one bit accordingly and N=WIDTH+1 regardless of tc; out is the 2*WIDTH-bit product in the selected interpretation.
REQ-025 Macro undefined: no tc port, always signed, N=WIDTH.

Structure
REQ-026 Shared package seq_booth_mult_pkg SHALL hold the state enum (IDLE, CALC, DONE) and the Booth-pair encoding constants.
REQ-027 One sub-module booth_step (combinational add/subtract/none plus arithmetic shift of the accumulator) SHALL be instantiated once; counter and FSM stay in the top.

Verification (WIDTH=16)
REQ-028 A=14, B=16, out_ready=1 -> out_valid rises 16 cycles after handshake, out=0x000000E0, IDLE on the next edge.
REQ-029 A=-3, B=5 then A=-32768, B=-32768 -> out=0xFFFFFFF1 then 0x40000000; A=0, B=16 -> 0x00000000.
REQ-030 out_ready held low 10 cycles after out_valid -> out_valid and out stable, in_ready=0, in_valid pulses ignored; out_ready high -> one-cycle acceptance, back to IDLE.
REQ-031 rst_n pulsed low at CALC cycle 7 -> same cycle out_valid=0, in_ready=1, out=0; next operation A=15, B=13 -> out=0x000000C3.
REQ-032 SEQ_BOOTH_MULT_UNSIGNED_EN defined: A=B=0xFFFF, tc=0 -> out=0xFFFE0001 after 17 cycles; tc=1 -> out=0x00000001.
